// File: rtl/param_universal_ring_shifter_if.sv
// Control and data bundle for the universal ring shifter: commands in, register state out.
interface param_universal_ring_shifter_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
);
    logic             load;
    logic [WIDTH-1:0] preset_value;
    logic             start;
    logic [CNT_W-1:0] steps;
    logic [1:0]       mode;
    logic             dir;
    logic             serial_in;
    logic [WIDTH-1:0] Q;
    logic             serial_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    modport master (
        output load, preset_value, start, steps, mode, dir, serial_in,
        input  Q, serial_out, busy, done, steps_left
    );

    modport slave (
        input  load, preset_value, start, steps, mode, dir, serial_in,
        output Q, serial_out, busy, done, steps_left
    );
endinterface

// File: rtl/param_universal_ring_shifter.sv
// WIDTH-bit ring/shift/Johnson register that runs a counted burst of steps per start command.
module param_universal_ring_shifter #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    param_universal_ring_shifter_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] M_ROT  = 2'b00;
    localparam logic [1:0] M_SER  = 2'b01;
    localparam logic [1:0] M_JOHN = 2'b10;

    state_t           state, state_n;
    logic [WIDTH-1:0] q, q_n;
    logic             so, so_n;
    logic             done, done_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       mode_r, mode_n;
    logic             dir_r, dir_n;
    logic             out_bit, fill;

    // Bit leaving the register and the bit entering at the opposite end.
    always_comb begin
        out_bit = dir_r ? q[0] : q[WIDTH-1];
        case (mode_r)
            M_ROT:   fill = out_bit;
            M_SER:   fill = bus.serial_in;
            M_JOHN:  fill = ~out_bit;
            default: fill = out_bit;
        endcase
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        so_n    = so;
        done_n  = 1'b0;
        cnt_n   = cnt;
        mode_n  = mode_r;
        dir_n   = dir_r;
        if (bus.load) begin
            q_n     = bus.preset_value;
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.steps == '0) begin
                            done_n = 1'b1;
                        end else begin
                            mode_n  = bus.mode;
                            dir_n   = bus.dir;
                            cnt_n   = bus.steps;
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    // Hold mode still counts down so the burst acts as a timed delay.
                    if (mode_r != 2'b11) begin
                        so_n = out_bit;
                        q_n  = dir_r ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
                    end
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            so     <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            mode_r <= 2'b00;
            dir_r  <= 1'b0;
        end else begin
            state  <= state_n;
            q      <= q_n;
            so     <= so_n;
            done   <= done_n;
            cnt    <= cnt_n;
            mode_r <= mode_n;
            dir_r  <= dir_n;
        end
    end

    assign bus.Q          = q;
    assign bus.serial_out = so;
    assign bus.busy       = (state == RUN);
    assign bus.done       = done;
    assign bus.steps_left = cnt;
endmodule

// File: tb/tb_param_universal_ring_shifter.sv
// Scoreboard bench: driver pushes model-predicted outputs per cycle, monitor pops and compares.
module tb_param_universal_ring_shifter;
    localparam int W  = 6;
    localparam int CW = 8;

    typedef struct packed {
        logic [W-1:0]  q;
        logic          so;
        logic          busy;
        logic          done;
        logic [CW-1:0] left;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_universal_ring_shifter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    param_universal_ring_shifter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    longint        m_q    = 0;
    logic          m_so   = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    int            m_left = 0;
    logic [1:0]    m_mode = 2'b00;
    logic          m_dir  = 1'b0;

    // Monitor
    exp_t mon_e, mon_a;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_a = '{q: bus.Q, so: bus.serial_out, busy: bus.busy,
                      done: bus.done, left: bus.steps_left};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL outputs t=%0t: got Q=%b so=%b busy=%b done=%b left=%0d, want Q=%b so=%b busy=%b done=%b left=%0d",
                         $time, mon_a.q, mon_a.so, mon_a.busy, mon_a.done, mon_a.left,
                         mon_e.q, mon_e.so, mon_e.busy, mon_e.done, mon_e.left);
            end
        end
    end

    task automatic model_step(input logic si);
        longint mask = (64'd1 << W) - 1;
        logic   top  = m_q[W-1];
        logic   bot  = m_q[0];
        logic   outb = m_dir ? bot : top;
        logic   f;
        if (m_mode == 2'b11) return;
        if (m_mode == 2'b00)      f = outb;
        else if (m_mode == 2'b01) f = si;
        else                      f = ~outb;
        m_so = outb;
        if (m_dir) m_q = (m_q >> 1) | (longint'(f) << (W - 1));
        else       m_q = ((m_q << 1) & mask) | longint'(f);
    endtask

    task automatic drive(input logic r, input logic ld, input logic [W-1:0] pv,
                         input logic st, input int n, input logic [1:0] md,
                         input logic d, input logic si);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.load         = ld;
        bus.preset_value = pv;
        bus.start        = st;
        bus.steps        = CW'(n);
        bus.mode         = md;
        bus.dir          = d;
        bus.serial_in    = si;
        m_done = 1'b0;
        if (r) begin
            m_q = 0; m_so = 1'b0; m_busy = 1'b0; m_left = 0; m_mode = 2'b00; m_dir = 1'b0;
        end else if (ld) begin
            m_q = longint'(pv); m_busy = 1'b0; m_left = 0;
        end else if (!m_busy) begin
            if (st) begin
                if (n == 0) m_done = 1'b1;
                else begin
                    m_busy = 1'b1; m_left = n; m_mode = md; m_dir = d;
                end
            end
        end else begin
            model_step(si);
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
            end
        end
        e = '{q: W'(m_q), so: m_so, busy: m_busy, done: m_done, left: CW'(m_left)};
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic si);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, 2'b00, 0, si);
    endtask

    task automatic rand_cycle(input int p_rst, input int p_load, input int p_start);
        drive(($urandom_range(0, 99) < p_rst),
              ($urandom_range(0, 99) < p_load),
              W'($urandom),
              ($urandom_range(0, 99) < p_start),
              int'($urandom_range(0, 14)),
              2'($urandom),
              1'($urandom),
              1'($urandom));
    endtask

    initial begin
        bus.load = 0; bus.preset_value = '0; bus.start = 0; bus.steps = '0;
        bus.mode = 2'b00; bus.dir = 0; bus.serial_in = 0;

        // Reset after random activity, held for two edges
        for (int i = 0; i < 20; i++) rand_cycle(0, 10, 40);
        drive(1, 0, '0, 0, 0, 2'b00, 0, 0);
        drive(1, 0, '0, 0, 0, 2'b00, 0, 0);

        // Rotate left 6 steps from 101010
        drive(0, 1, 6'b101010, 0, 0, 2'b00, 0, 0);
        drive(0, 0, '0, 1, 6, 2'b00, 0, 0);
        idle(8, 0);

        // Rotate right single step from 000001
        drive(0, 1, 6'b000001, 0, 0, 2'b00, 0, 0);
        drive(0, 0, '0, 1, 1, 2'b00, 1, 0);
        idle(3, 0);

        // Johnson left: full period of 2*W
        drive(0, 1, 6'b000000, 0, 0, 2'b00, 0, 0);
        drive(0, 0, '0, 1, 12, 2'b10, 0, 0);
        idle(14, 0);

        // Serial shift left with serial_in=1
        drive(0, 1, 6'b101010, 0, 0, 2'b00, 0, 1);
        drive(0, 0, '0, 1, 3, 2'b01, 0, 1);
        idle(5, 1);

        // steps=0 start
        drive(0, 0, '0, 1, 0, 2'b00, 0, 0);
        idle(2, 0);

        // start during RUN is ignored
        drive(0, 0, '0, 1, 5, 2'b10, 1, 0);
        idle(2, 0);
        drive(0, 0, '0, 1, 9, 2'b00, 0, 0);
        idle(5, 0);

        // load at step 3 of 8-step burst
        drive(0, 0, '0, 1, 8, 2'b00, 0, 0);
        idle(2, 0);
        drive(0, 1, 6'b110011, 0, 0, 2'b00, 0, 0);
        idle(3, 0);

        // load with start in the same cycle
        drive(0, 1, 6'b011100, 1, 4, 2'b00, 0, 0);
        idle(3, 0);

        // Reset mid-burst aborts without done
        drive(0, 0, '0, 1, 10, 2'b01, 1, 1);
        idle(3, 1);
        drive(1, 0, '0, 0, 0, 2'b00, 0, 0);
        idle(3, 0);

        // Hold mode as a delay
        drive(0, 1, 6'b100111, 0, 0, 2'b00, 0, 0);
        drive(0, 0, '0, 1, 4, 2'b11, 1, 1);
        idle(6, 1);

        // Random soak
        for (int i = 0; i < 600; i++) rand_cycle(1, 3, 30);
        idle(20, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
